// File: rtl/ram_chk.sv
// ram_chk: passive read-back checker for a single-port RAM.
// Shadows every write and compares each read result after RD_LAT edges.
module ram_chk #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int LED_HALF = 25_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_wr_en,
  input  logic              ram_rd_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              err_flag,
  output logic [15:0]       err_cnt,
  output logic [15:0]       chk_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              led
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [24:0] HALF_M1 = 25'(LED_HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic [RD_LAT-1:0] p_cmp;
  logic [ADDR_W-1:0] p_addr [RD_LAT];
  logic [DATA_W-1:0] p_exp  [RD_LAT];

  logic        issue;
  logic        cmp;
  logic        miss;
  logic        pass;
  logic [24:0] blink;

  // a collision cycle is a write only: the RAM honours the write
  assign issue = ram_rd_en & ~ram_wr_en;

  // shadow data survives reset; only the valid bits are cleared
  always_ff @(posedge clk) begin
    if (ram_wr_en)
      shadow[ram_addr] <= ram_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      vld <= '0;
    else if (ram_wr_en)
      vld[ram_addr] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_cmp <= '0;
    end else begin
      p_cmp[0] <= issue & vld[ram_addr];
      for (int i = 1; i < RD_LAT; i++)
        p_cmp[i] <= p_cmp[i-1];
    end
  end

  // expectation is frozen at issue time
  always_ff @(posedge clk) begin
    p_addr[0] <= ram_addr;
    p_exp[0]  <= shadow[ram_addr];
    for (int i = 1; i < RD_LAT; i++) begin
      p_addr[i] <= p_addr[i-1];
      p_exp[i]  <= p_exp[i-1];
    end
  end

  assign cmp  = p_cmp[RD_LAT-1];
  assign miss = cmp && (ram_rd_data != p_exp[RD_LAT-1]);
  assign pass = cmp && !miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_cnt  <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      if (cmp && chk_cnt != 16'hFFFF)
        chk_cnt <= chk_cnt + 16'd1;
      if (miss) begin
        if (err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
        if (!err_flag)
          err_addr <= p_addr[RD_LAT-1];
        err_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          miss:    state_d = FAIL;
          pass:    state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
      RUN:     if (miss) state_d = FAIL;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink <= '0;
      led   <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          blink <= '0;
          led   <= 1'b1;
        end
        FAIL: begin
          if (blink == HALF_M1) begin
            blink <= '0;
            led   <= ~led;
          end else begin
            blink <= blink + 25'd1;
          end
        end
        default: begin
          blink <= '0;
          led   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_chk.sv
// tb_ram_chk: random and directed stimulus for ram_chk,
// scored against a queue-based model of the checker rules.
module tb_ram_chk;

  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int HALF = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  logic          err_flag;
  logic [15:0]   err_cnt;
  logic [15:0]   chk_cnt;
  logic [AW-1:0] err_addr;
  logic          led;
  logic          fault;

  always #5 clk = ~clk;

  ram_chk #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .LED_HALF(HALF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .err_flag(err_flag), .err_cnt(err_cnt),
    .chk_cnt(chk_cnt), .err_addr(err_addr),
    .led(led)
  );

  // RAM with two-edge read latency; fault forces 0xFF onto a read
  logic [DW-1:0] ram [32];
  logic [DW-1:0] dl1;
  logic [DW-1:0] dl2;

  always @(posedge clk) begin
    if (ram_wr_en)
      ram[ram_addr] <= ram_wr_data;
    else if (ram_rd_en)
      dl1 <= fault ? 8'hFF : ram[ram_addr];
    else
      dl1 <= 8'($urandom);
    dl2 <= dl1;
  end

  assign ram_rd_data = dl2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  typedef struct {
    longint        due;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    logic [DW-1:0] got;
  } rd_t;

  rd_t           q[$];
  logic [DW-1:0] m_data [32];
  bit            m_vld  [32];
  int            m_chk;
  int            m_err;
  bit            m_flag;
  int            m_eaddr;
  int            m_state;
  bit            m_led;
  bit            led_known;
  longint        cyc = 0;

  task automatic m_reset();
    q.delete();
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    m_chk = 0; m_err = 0; m_flag = 0; m_eaddr = 0;
    m_state = 0; m_led = 0; led_known = 1;
  endtask

  task automatic model_edge(input bit wr, input bit rd,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] wd,
                            input bit bad, input bit rs);
    int old;
    rd_t e;
    cyc++;
    if (!rs) begin
      m_reset();
      if (wr) m_data[a] = wd;
      return;
    end
    old = m_state;
    led_known = (old != 2);
    m_led = (old == 1);
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      if (m_chk < 16'hFFFF) m_chk++;
      if (e.got != e.exp) begin
        if (m_err < 16'hFFFF) m_err++;
        if (!m_flag) m_eaddr = int'(e.a);
        m_flag = 1;
        m_state = 2;
      end else if (m_state == 0) begin
        m_state = 1;
      end
    end
    if (wr) begin
      m_data[a] = wd;
      m_vld[a] = 1'b1;
    end else if (rd && m_vld[a]) begin
      e.due = cyc + LAT;
      e.a   = a;
      e.exp = m_data[a];
      e.got = bad ? 8'hFF : ram[a];
      q.push_back(e);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input int a,
                      input int wd, input bit bad, input bit rs);
    ram_wr_en   = wr;
    ram_rd_en   = rd;
    ram_addr    = AW'(a);
    ram_wr_data = DW'(wd);
    fault       = bad;
    rst_n       = rs;
    @(posedge clk);
    model_edge(wr, rd, AW'(a), DW'(wd), bad, rs);
    @(negedge clk);
    check("err_flag", 32'(err_flag), 32'(m_flag));
    check("err_cnt",  32'(err_cnt),  32'(m_err));
    check("chk_cnt",  32'(chk_cnt),  32'(m_chk));
    check("err_addr", 32'(err_addr), 32'(m_eaddr));
    if (led_known) check("led", 32'(led), 32'(m_led));
  endtask

  task automatic wr_w(input int a, input int d);
    step(1, 0, a, d, 0, 1);
  endtask

  task automatic rd_w(input int a, input bit bad);
    step(0, 1, a, 0, bad, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic rst();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  logic led_h [32];
  int   last;
  int   ntog;

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i]    = 8'($urandom);
      m_data[i] = 8'h00;
    end
    m_reset();
    rst();

    // clean sweep
    for (int i = 0; i < 32; i++) wr_w(i, i);
    for (int i = 0; i < 32; i++) rd_w(i, 0);
    idle(4);
    check("sweep_chk",  32'(chk_cnt),  32);
    check("sweep_err",  32'(err_cnt),  0);
    check("sweep_flag", 32'(err_flag), 0);
    check("sweep_led",  32'(led),      1);

    // injected fault at address 5
    rst();
    for (int i = 0; i < 32; i++) wr_w(i, i);
    for (int i = 0; i < 32; i++) rd_w(i, i == 5);
    idle(4);
    check("fault_err",  32'(err_cnt),  1);
    check("fault_flag", 32'(err_flag), 1);
    check("fault_addr", 32'(err_addr), 5);
    check("fault_chk",  32'(chk_cnt),  32);
    for (int i = 0; i < 32; i++) begin
      idle(1);
      led_h[i] = led;
    end
    last = -1;
    ntog = 0;
    for (int i = 1; i < 32; i++) begin
      if (led_h[i] != led_h[i-1]) begin
        if (last >= 0) check("blink_gap", 32'(i - last), HALF);
        last = i;
        ntog++;
      end
    end
    check("blink_toggles", 32'(ntog >= 6), 1);

    // unwritten read, then collision, then read back
    rst();
    rd_w(7, 0);
    step(1, 1, 3, 8'hA5, 0, 1);
    rd_w(3, 0);
    idle(4);
    check("coll_chk", 32'(chk_cnt), 1);
    check("coll_err", 32'(err_cnt), 0);

    // overwrite while the read is in flight
    rst();
    wr_w(2, 8'h11);
    rd_w(2, 0);
    wr_w(2, 8'h22);
    idle(4);
    check("ovw_err", 32'(err_cnt), 0);
    check("ovw_chk", 32'(chk_cnt), 1);

    // reset right after a read that returns bad data
    rst();
    wr_w(6, 8'h40);
    rd_w(6, 1);
    step(0, 0, 0, 0, 1, 0);
    rd_w(6, 1);
    idle(4);
    check("rstmid_err",  32'(err_cnt),  0);
    check("rstmid_chk",  32'(chk_cnt),  0);
    check("rstmid_flag", 32'(err_flag), 0);
    check("rstmid_led",  32'(led),      0);

    // randomized traffic with occasional reset
    rst();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 31)),
           int'($urandom_range(0, 255)),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 199) != 0);
    end
    idle(4);

    // saturation of both counters
    rst();
    wr_w(9, 8'h3C);
    wr_w(12, 8'h55);
    for (int i = 0; i < 65536; i++) rd_w(9, 1);
    for (int i = 0; i < 3; i++) rd_w(12, 1);
    idle(4);
    check("sat_err",  32'(err_cnt),  32'hFFFF);
    check("sat_chk",  32'(chk_cnt),  32'hFFFF);
    check("sat_addr", 32'(err_addr), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_chk.md
# ram_chk

Read-back checker for the single-port RAM interface driven by `ram_rw`. It is a passive tap on the same address, data and enable nets. It keeps a shadow copy of every word written and compares each read result against that copy after the RAM read latency. Mismatches are reported on counters, a sticky flag and an LED, so a board-level RAM experiment becomes self-checking without SignalTap.

## Interface
- `ADDR_W`, 5: RAM address width; the shadow depth is 2^ADDR_W.
- `DATA_W`, 8: RAM data width.
- `RD_LAT`, 1: edges from a sampled `ram_rd_en` to a valid `ram_rd_data`; legal values are 1 or 2.
- `LED_HALF`, 25_000_000: half-period of the LED blink in the FAIL state, in `clk` cycles.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ram_wr_en`  in  1  RAM write enable, tapped.
- `ram_rd_en`  in  1  RAM read enable, tapped.
- `ram_addr`  in  ADDR_W  RAM address, tapped.
- `ram_wr_data`  in  DATA_W  RAM write data, tapped.
- `ram_rd_data`  in  DATA_W  RAM read data (`q`), tapped.
- `err_flag`  out  1  sticky: at least one mismatch since reset.
- `err_cnt`  out  16  mismatch count, saturates at 0xFFFF.
- `chk_cnt`  out  16  count of compared reads, saturates at 0xFFFF.
- `err_addr`  out  ADDR_W  address of the first mismatch; held after it is captured.
- `led`  out  1  status indicator.

## Operation
- Shadow store: a 2^ADDR_W x DATA_W array plus one valid bit per entry.
- Write: on an edge with `ram_wr_en`=1, set `shadow[ram_addr]` to `ram_wr_data` and set the entry's valid bit to 1.
- Read issue: on an edge with `ram_rd_en`=1 and `ram_wr_en`=0, push {addr, `shadow[addr]`, valid bit} into an RD_LAT-deep pipeline.
  - The expected value is captured at issue time.
  - A later write to the same address does not change an in-flight expectation.
- Simultaneous `ram_wr_en`=1 and `ram_rd_en`=1: the RAM honours the write.
  - The checker treats the cycle as a write only.
  - No compare is issued and `chk_cnt` is unchanged.
- Compare: at the pipeline output, if the entry was valid:
  - `chk_cnt` is incremented.
  - If `ram_rd_data` differs from the expected value:
    - `err_cnt` is incremented.
    - `err_flag` is set to 1.
    - `err_addr` is loaded, only if `err_flag` was 0.
- Reads of never-written addresses are not compared and produce no error.
- Reads may be back-to-back, one per cycle; the pipeline accepts one read per edge without stall.
- Counters saturate and do not wrap.
- State machine, 2-bit state:
  - IDLE: no valid compare yet; `led`=0. Goes to RUN on the first passing compare, or to FAIL on the first mismatch.
  - RUN: `led`=1. Goes to FAIL on any mismatch.
  - FAIL: `led` toggles every LED_HALF cycles using a 25-bit counter. FAIL is absorbing; only reset leaves it.
- Reset (`rst_n`=0 at an edge) clears:
  - all valid bits;
  - the pipeline, so in-flight reads are discarded;
  - all counters;
  - the state, to IDLE.
  The shadow data contents are not cleared.
- Reset values: `err_flag`=0, `err_cnt`=0, `chk_cnt`=0, `err_addr`=0, `led`=0, blink counter=0.

## Timing
- Read sampled at edge E0; `ram_rd_data` is sampled at edge E0+RD_LAT.
- `chk_cnt`, `err_cnt`, `err_flag`, `err_addr` and the state update at edge E0+RD_LAT.
- `led` is registered from the state: it changes at edge E0+RD_LAT+1.
- A write at edge E0 is visible to a read issued at edge E0+1 (shadow write then read, no bypass needed). A read at the same edge as the write is a collision, covered under Operation.
- Reset applied at edge Er: all outputs hold their reset values from Er onward. A read issued at Er-1 produces no compare.

## Test plan
- Clean sweep:
  - Stimulus: write addresses 0..31 with data=addr, then read 0..31 back-to-back with a correct RAM model.
  - Required: `chk_cnt`=32, `err_cnt`=0, `err_flag`=0, `led`=1 from the cycle after the first compare.
- Injected fault:
  - Stimulus: same sweep, but force `ram_rd_data`=0xFF on the read of address 5.
  - Required: `err_cnt`=1, `err_flag`=1, `err_addr`=5, `chk_cnt`=32, state FAIL. With LED_HALF=4 in simulation, `led` toggles every 4 cycles.
- Unwritten and collision cases:
  - Stimulus: after reset, read address 7 with no prior write, then assert wr_en and rd_en together on address 3 with data 0xA5, then read address 3.
  - Required: `chk_cnt`=1, `err_cnt`=0, expected value 0xA5.
- In-flight overwrite:
  - Stimulus: RD_LAT=2; write 0x11 to addr 2; read addr 2; write 0x22 to addr 2 on the next cycle; the RAM returns 0x11.
  - Required: no error.
- Reset mid-operation:
  - Stimulus: pulse `rst_n` low for one edge at the edge after a read issue, while the RAM returns bad data.
  - Required: `err_cnt`=0, state IDLE, all valid bits clear, so a following read of that address is not compared.
- Saturation:
  - Stimulus: preload `err_cnt` to 0xFFFE via forced mismatches (or a force in the bench), then apply 3 more mismatches.
  - Required: `err_cnt`=0xFFFF and it stays there; `err_addr` is unchanged from the first fault.
